// File: rtl/display_pkg.sv
// Shared constants, object-word field layout and sprite ROM contents for the
// XVGA compositor path.
package display_pkg;

  localparam int OBJ_WORD_W = 26;
  localparam int FRAME_HI   = 25;
  localparam int FRAME_LO   = 23;
  localparam int TYPE_HI    = 22;
  localparam int TYPE_LO    = 21;
  localparam int X_HI       = 20;
  localparam int X_LO       = 10;
  localparam int Y_HI       = 9;
  localparam int Y_LO       = 0;

  localparam logic [11:0] TRANSPARENT   = 12'h000;
  localparam logic [11:0] DEF_LOWER_RGB = 12'h00F;
  localparam logic [11:0] DEF_UPPER_RGB = 12'hFFF;
  localparam logic [9:0]  RESET_VPOS    = 10'd384;

  typedef enum logic [1:0] {
    CHAR_STILL = 2'd0,
    CHAR_RISE  = 2'd1,
    CHAR_FALL  = 2'd2
  } char_frame_e;

  // Character art: solid body tinted by animation frame, top-left pixel cut out.
  function automatic logic [11:0] sprite_rom(input logic [1:0]  frame,
                                             input logic [11:0] rx,
                                             input logic [11:0] ry);
    logic [11:0] c;
    case (char_frame_e'(frame))
      CHAR_RISE: c = 12'hF80;
      CHAR_FALL: c = 12'hF08;
      default:   c = 12'hF00;
    endcase
    return ((rx == 12'd0) && (ry == 12'd0)) ? TRANSPARENT : c;
  endfunction

  // Collectable art: colour by type, low bits perturbed by frame; the left
  // column and row 8 are see-through gaps.
  function automatic logic [11:0] collectable_rom(input logic [2:0]  frame,
                                                  input logic [1:0]  typ,
                                                  input logic [11:0] rx,
                                                  input logic [11:0] ry);
    logic [11:0] c;
    case (typ)
      2'd0:    c = 12'h0F0;
      2'd1:    c = 12'hFF0;
      2'd2:    c = 12'h0FF;
      default: c = 12'hF0F;
    endcase
    return ((rx == 12'd0) || (ry == 12'd8)) ? TRANSPARENT : (c ^ {9'd0, frame});
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite: 12-bit clipped bounds test, sprite-relative coordinates and ROM
// lookup. key_i = {is_char, frame[2:0], type[1:0]}.
module sprite_slot
  import display_pkg::*;
#(
  parameter int W = 15,
  parameter int H = 16
)(
  input  logic [10:0] hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic [10:0] x_i,
  input  logic [9:0]  y_i,
  input  logic [5:0]  key_i,
  input  logic        en_i,
  output logic        opaque_o,
  output logic [11:0] rgb_o
);

  logic [11:0] col, row, left, top, rel_x, rel_y, pix;
  logic        in_box;

  assign col  = {1'b0, hcount_i};
  assign row  = {2'b00, vcount_i};
  assign left = {1'b0, x_i};
  assign top  = {2'b00, y_i};

  // Widened sums let boxes hanging off column 2047 / row 1023 clip instead of wrapping.
  assign in_box = (col >= left) && (col < left + 12'(W)) &&
                  (row >= top)  && (row < top + 12'(H));

  assign rel_x = col - left;
  assign rel_y = row - top;

  assign pix = key_i[5] ? sprite_rom(key_i[3:2], rel_x, rel_y)
                        : collectable_rom(key_i[4:2], key_i[1:0], rel_x, rel_y);

  assign opaque_o = en_i & in_box & (pix != TRANSPARENT);
  assign rgb_o    = pix;

endmodule

// File: rtl/sprite_compositor.sv
// Frame-latched character + N_OBJ objects composited over a two-colour wave
// background in two pipeline stages, with per-frame collision reporting.
module sprite_compositor
  import display_pkg::*;
#(
  parameter int          N_OBJ     = 5,
  parameter int          CHAR_X    = 0,
  parameter int          CHAR_W    = 20,
  parameter int          CHAR_H    = 20,
  parameter int          OBJ_W     = 15,
  parameter int          OBJ_H     = 16,
  parameter logic [11:0] LOWER_RGB = DEF_LOWER_RGB,
  parameter logic [11:0] UPPER_RGB = DEF_UPPER_RGB
)(
  input  logic                        vclock,
  input  logic                        reset,
  input  logic [10:0]                 hcount,
  input  logic [9:0]                  vcount,
  input  logic                        vsync,
  input  logic                        blank,
  input  logic [9:0]                  wave_prof,
  input  logic [9:0]                  p_vpos,
  input  logic [1:0]                  char_frame,
  input  logic [OBJ_WORD_W*N_OBJ-1:0] p_obj,
  output logic [11:0]                 p_rgb,
  output logic [N_OBJ-1:0]            hit,
  output logic                        hit_valid
);

  logic                                 vsync_q;
  logic                                 frame_edge;
  logic [9:0]                           vpos_q, vpos_d;
  logic [1:0]                           cframe_q, cframe_d;
  logic [N_OBJ-1:0][OBJ_WORD_W-1:0]     obj_q, obj_d;

  assign frame_edge = vsync_q & ~vsync;

  always_comb begin
    vpos_d   = vpos_q;
    cframe_d = cframe_q;
    obj_d    = obj_q;
    if (frame_edge) begin
      vpos_d   = p_vpos;
      cframe_d = char_frame;
      obj_d    = p_obj;
    end
  end

  logic                   char_op;
  logic [11:0]            char_rgb;
  logic [N_OBJ-1:0]       obj_op;
  logic [N_OBJ-1:0][11:0] obj_rgb;

  sprite_slot #(.W(CHAR_W), .H(CHAR_H)) u_char (
    .hcount_i (hcount),
    .vcount_i (vcount),
    .x_i      (11'(CHAR_X)),
    .y_i      (vpos_q),
    .key_i    ({1'b1, 1'b0, cframe_q, 2'b00}),
    .en_i     (1'b1),
    .opaque_o (char_op),
    .rgb_o    (char_rgb)
  );

  for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
    sprite_slot #(.W(OBJ_W), .H(OBJ_H)) u_obj (
      .hcount_i (hcount),
      .vcount_i (vcount),
      .x_i      (obj_q[i][X_HI:X_LO]),
      .y_i      (obj_q[i][Y_HI:Y_LO]),
      .key_i    ({1'b0, obj_q[i][FRAME_HI:FRAME_LO], obj_q[i][TYPE_HI:TYPE_LO]}),
      .en_i     (|obj_q[i]),
      .opaque_o (obj_op[i]),
      .rgb_o    (obj_rgb[i])
    );
  end

  logic                   s1_char_op_q, s1_below_q, s1_blank_q;
  logic [11:0]            s1_char_rgb_q;
  logic [N_OBJ-1:0]       s1_obj_op_q;
  logic [N_OBJ-1:0][11:0] s1_obj_rgb_q;
  logic [11:0]            rgb_q, rgb_d;
  logic [N_OBJ-1:0]       acc_q, acc_d, hit_q, hit_d, coll;
  logic                   hit_valid_q;

  // Lowest slot index wins among objects; the character beats every object.
  always_comb begin
    rgb_d = s1_below_q ? LOWER_RGB : UPPER_RGB;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (s1_obj_op_q[i]) rgb_d = s1_obj_rgb_q[i];
    end
    if (s1_char_op_q) rgb_d = s1_char_rgb_q;
    if (s1_blank_q)   rgb_d = '0;
  end

  assign coll = {N_OBJ{s1_char_op_q & ~s1_blank_q}} & s1_obj_op_q;

  always_comb begin
    acc_d = acc_q | coll;
    hit_d = hit_q;
    if (frame_edge) begin
      acc_d = '0;
      hit_d = acc_q;
    end
  end

  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      vsync_q       <= 1'b1;
      vpos_q        <= RESET_VPOS;
      cframe_q      <= 2'd0;
      obj_q         <= '0;
      s1_char_op_q  <= 1'b0;
      s1_char_rgb_q <= '0;
      s1_obj_op_q   <= '0;
      s1_obj_rgb_q  <= '0;
      s1_below_q    <= 1'b0;
      s1_blank_q    <= 1'b1;
      rgb_q         <= '0;
      acc_q         <= '0;
      hit_q         <= '0;
      hit_valid_q   <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      vpos_q        <= vpos_d;
      cframe_q      <= cframe_d;
      obj_q         <= obj_d;
      s1_char_op_q  <= char_op;
      s1_char_rgb_q <= char_rgb;
      s1_obj_op_q   <= obj_op;
      s1_obj_rgb_q  <= obj_rgb;
      s1_below_q    <= (vcount > wave_prof);
      s1_blank_q    <= blank;
      rgb_q         <= rgb_d;
      acc_q         <= acc_d;
      hit_q         <= hit_d;
      hit_valid_q   <= frame_edge;
    end
  end

  assign p_rgb     = rgb_q;
  assign hit       = hit_q;
  assign hit_valid = hit_valid_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: background, priority, frame latching,
// collision reporting, clipping, blanking and asynchronous reset.
module tb_sprite_compositor;

  localparam int N = 5;

  logic          vclock = 1'b0;
  logic          reset;
  logic [10:0]   hcount;
  logic [9:0]    vcount;
  logic          vsync;
  logic          blank;
  logic [9:0]    wave_prof;
  logic [9:0]    p_vpos;
  logic [1:0]    char_frame;
  logic [26*N-1:0] p_obj;
  logic [11:0]   p_rgb;
  logic [N-1:0]  hit;
  logic          hit_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [N-1:0] seen_hit;
  int           seen_hv;

  sprite_compositor dut (
    .vclock     (vclock),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .vsync      (vsync),
    .blank      (blank),
    .wave_prof  (wave_prof),
    .p_vpos     (p_vpos),
    .char_frame (char_frame),
    .p_obj      (p_obj),
    .p_rgb      (p_rgb),
    .hit        (hit),
    .hit_valid  (hit_valid)
  );

  always #5 vclock = ~vclock;

  function automatic logic [25:0] obj_word(input logic [2:0] f, input logic [1:0] t,
                                           input logic [10:0] x, input logic [9:0] y);
    return {f, t, x, y};
  endfunction

  // Drive one pixel on a falling edge and wait until its p_rgb (t+2) is visible.
  task automatic show(input logic [10:0] h, input logic [9:0] v, input logic b);
    @(negedge vclock);
    hcount = h;
    vcount = v;
    blank  = b;
    @(posedge vclock);
    @(posedge vclock);
    #1;
  endtask

  // Blanked vsync falling edge; records the hit word and how many cycles hit_valid was seen.
  task automatic frame_edge(output logic [N-1:0] h, output int hv);
    h  = '0;
    hv = 0;
    @(negedge vclock);
    blank = 1'b1;
    vsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge vclock);
      if (hit_valid === 1'b1) begin
        hv++;
        h = hit;
      end
      vsync = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; vsync = 1'b1; blank = 1'b1; hcount = '0; vcount = '0;
    wave_prof = 10'd400; p_vpos = 10'd300; char_frame = 2'd0; p_obj = '0;
    repeat (3) @(posedge vclock);
    #1;
    n_cmp++; if (p_rgb !== 12'h000) begin n_fail++; $display("FAIL reset_p_rgb: got %h want 000", p_rgb); end
    n_cmp++; if (hit !== 5'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 00000", hit); end
    n_cmp++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hit_valid: got %b want 0", hit_valid); end
    @(negedge vclock);
    reset = 1'b0;
    show(11'd10, 10'd390, 1'b0);
    n_cmp++; if (p_rgb !== 12'hF00) begin n_fail++; $display("FAIL reset_vpos_char: got %h want F00", p_rgb); end
    show(11'd0, 10'd384, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL char_corner_clear: got %h want FFF", p_rgb); end
  endtask

  task automatic test_background;
    show(11'd100, 10'd399, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL bg_above: got %h want FFF", p_rgb); end
    show(11'd100, 10'd401, 1'b0);
    n_cmp++; if (p_rgb !== 12'h00F) begin n_fail++; $display("FAIL bg_below: got %h want 00F", p_rgb); end
    show(11'd100, 10'd400, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL bg_on_wave: got %h want FFF", p_rgb); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] hs [4];
    logic [9:0]  vs [4];
    logic [11:0] es [4];
    hs = '{11'd100, 11'd100, 11'd10, 11'd100};
    vs = '{10'd399, 10'd401, 10'd390, 10'd400};
    es = '{12'hFFF, 12'h00F, 12'hF00, 12'hFFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge vclock);
      if (i >= 2) begin
        n_cmp++;
        if (p_rgb !== es[i-2]) begin
          n_fail++; $display("FAIL stream_px%0d: got %h want %h", i - 2, p_rgb, es[i-2]);
        end
      end
      if (i < 4) begin hcount = hs[i]; vcount = vs[i]; blank = 1'b0; end
    end
  endtask

  task automatic test_priority;
    p_obj = '0;
    p_obj[26*0 +: 26] = obj_word(3'd0, 2'd0, 11'd100, 10'd300);
    p_obj[26*1 +: 26] = obj_word(3'd0, 2'd1, 11'd105, 10'd300);
    frame_edge(seen_hit, seen_hv);
    show(11'd110, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'h0F0) begin n_fail++; $display("FAIL slot0_over_slot1: got %h want 0F0", p_rgb); end
    show(11'd105, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'h0F0) begin n_fail++; $display("FAIL slot1_clear_col: got %h want 0F0", p_rgb); end
    show(11'd119, 10'd315, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFF0) begin n_fail++; $display("FAIL slot1_corner: got %h want FF0", p_rgb); end
    show(11'd120, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL slot1_right_edge: got %h want FFF", p_rgb); end
    show(11'd110, 10'd308, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL gap_row: got %h want FFF", p_rgb); end
    show(11'd0, 10'd0, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL empty_slot: got %h want FFF", p_rgb); end
  endtask

  task automatic test_midframe;
    p_obj[26*0 +: 26] = obj_word(3'd0, 2'd0, 11'd200, 10'd300);
    show(11'd110, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'h0F0) begin n_fail++; $display("FAIL mid_old_pos: got %h want 0F0", p_rgb); end
    show(11'd205, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL mid_new_pos_hidden: got %h want FFF", p_rgb); end
    frame_edge(seen_hit, seen_hv);
    show(11'd110, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFF0) begin n_fail++; $display("FAIL next_old_pos: got %h want FF0", p_rgb); end
    show(11'd205, 10'd305, 1'b0);
    n_cmp++; if (p_rgb !== 12'h0F0) begin n_fail++; $display("FAIL next_new_pos: got %h want 0F0", p_rgb); end
  endtask

  task automatic test_collision;
    p_vpos = 10'd300;
    char_frame = 2'd1;
    p_obj = '0;
    p_obj[26*2 +: 26] = obj_word(3'd0, 2'd2, 11'd10, 10'd305);
    frame_edge(seen_hit, seen_hv);
    n_cmp++; if (seen_hit !== 5'b00000) begin n_fail++; $display("FAIL no_overlap_hit: got %b want 00000", seen_hit); end
    show(11'd12, 10'd310, 1'b0);
    n_cmp++; if (p_rgb !== 12'hF80) begin n_fail++; $display("FAIL char_over_slot2: got %h want F80", p_rgb); end
    show(11'd0, 10'd300, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL char_clear_corner: got %h want FFF", p_rgb); end
    frame_edge(seen_hit, seen_hv);
    n_cmp++; if (seen_hit !== 5'b00100) begin n_fail++; $display("FAIL hit_slot2: got %b want 00100", seen_hit); end
    n_cmp++; if (seen_hv !== 1) begin n_fail++; $display("FAIL hit_valid_width: got %0d cycles want 1", seen_hv); end
    show(11'd100, 10'd100, 1'b0);
    frame_edge(seen_hit, seen_hv);
    n_cmp++; if (seen_hit !== 5'b00000) begin n_fail++; $display("FAIL hit_cleared: got %b want 00000", seen_hit); end
    n_cmp++; if (seen_hv !== 1) begin n_fail++; $display("FAIL hit_valid_again: got %0d cycles want 1", seen_hv); end
  endtask

  task automatic test_clip;
    p_obj = '0;
    p_obj[26*0 +: 26] = obj_word(3'd0, 2'd3, 11'd2040, 10'd100);
    p_obj[26*1 +: 26] = obj_word(3'd0, 2'd0, 11'd500, 10'd1012);
    frame_edge(seen_hit, seen_hv);
    show(11'd2047, 10'd105, 1'b0);
    n_cmp++; if (p_rgb !== 12'hF0F) begin n_fail++; $display("FAIL clip_right_col: got %h want F0F", p_rgb); end
    show(11'd2, 10'd105, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL clip_no_wrap_low: got %h want FFF", p_rgb); end
    show(11'd6, 10'd105, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL clip_no_wrap_col6: got %h want FFF", p_rgb); end
    show(11'd505, 10'd1023, 1'b0);
    n_cmp++; if (p_rgb !== 12'h0F0) begin n_fail++; $display("FAIL clip_bottom_row: got %h want 0F0", p_rgb); end
    show(11'd2047, 10'd105, 1'b1);
    n_cmp++; if (p_rgb !== 12'h000) begin n_fail++; $display("FAIL blank_in_sprite: got %h want 000", p_rgb); end
  endtask

  task automatic test_reset_midframe;
    p_obj = '0;
    p_obj[26*2 +: 26] = obj_word(3'd0, 2'd2, 11'd10, 10'd305);
    frame_edge(seen_hit, seen_hv);
    show(11'd12, 10'd310, 1'b0);
    n_cmp++; if (p_rgb !== 12'hF80) begin n_fail++; $display("FAIL pre_reset_overlap: got %h want F80", p_rgb); end
    @(negedge vclock);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (p_rgb !== 12'h000) begin n_fail++; $display("FAIL async_p_rgb: got %h want 000", p_rgb); end
    n_cmp++; if (hit_valid !== 1'b0) begin n_fail++; $display("FAIL async_hit_valid: got %b want 0", hit_valid); end
    @(negedge vclock);
    reset = 1'b0;
    show(11'd10, 10'd390, 1'b0);
    n_cmp++; if (p_rgb !== 12'hF00) begin n_fail++; $display("FAIL post_reset_char: got %h want F00", p_rgb); end
    show(11'd12, 10'd310, 1'b0);
    n_cmp++; if (p_rgb !== 12'hFFF) begin n_fail++; $display("FAIL post_reset_slots_empty: got %h want FFF", p_rgb); end
    frame_edge(seen_hit, seen_hv);
    n_cmp++; if (seen_hit !== 5'b00000) begin n_fail++; $display("FAIL post_reset_hit: got %b want 00000", seen_hit); end
    n_cmp++; if (seen_hv !== 1) begin n_fail++; $display("FAIL post_reset_hit_valid: got %0d cycles want 1", seen_hv); end
  endtask

  initial begin
    test_reset();
    test_background();
    test_back_to_back();
    test_priority();
    test_midframe();
    test_collision();
    test_clip();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
